ram_loader: RTL
===============

Name: ram_loader

Overview:
Serial boot loader that sits directly upstream of the main RAM write port. It consumes a byte stream from the UART receiver, parses a framed download (sync, start address, word count, big-endian data words, checksum) and issues one-cycle RAM write strobes with address and data. It holds the CPU stalled while a frame is in progress and reports DONE or ERROR at frame end. RAM writes are not rolled back on a bad checksum.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker; bytes not equal to it are ignored while idle
TIMEOUT_CYCLES, 1000000, maximum gap in clock cycles between accepted bytes inside a frame before the frame is aborted

Ports:
CLK  input  1  system clock; all logic on the rising edge
RESET  input  1  synchronous reset, active high
RX_DATA  input  8  received byte from the UART receiver
RX_VALID  input  1  one-cycle strobe; RX_DATA is valid and accepted in this cycle
LOAD  output  1  RAM write enable; one-cycle pulse per data word
ADDRESS  output  16  RAM write address
DATA_IN  output  16  RAM write data
HOLD  output  1  CPU stall request; high for the whole frame
DONE  output  1  one-cycle pulse: frame finished, checksum good
ERROR  output  1  one-cycle pulse: checksum bad or inter-byte timeout

Behaviour:
- Interface: one clock (CLK); RESET is synchronous and active-high. On a RESET edge: state IDLE; LOAD, HOLD, DONE, ERROR = 0; ADDRESS, DATA_IN = 16'h0000; internal counters and checksum cleared.
- Frame: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT x (DATA_HI, DATA_LO), then CHK. All multi-byte fields are big-endian.
- Checksum: 8-bit wrapping sum of every byte after SYNC, including CHK, must equal 8'h00.
- States: IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CHECK. Each accepted byte advances exactly one state.
- IDLE: RX_VALID with RX_DATA == SYNC_BYTE moves to ADDR_HI, sets HOLD = 1 on the same edge, and clears the checksum. All other bytes are dropped.
- CNT_LO: if the assembled count is 0, go to CHECK; otherwise go to DATA_HI.
- DATA_LO accept:
  - On that edge, register ADDRESS = current write pointer, DATA_IN = {hi, lo}, and LOAD = 1 (exactly one cycle).
  - Increment the pointer, mod 2^16: 16'hFFFF wraps to 16'h0000.
  - Decrement the remaining count. Go to DATA_HI, or to CHECK when the count reaches 0.
  - LOAD is registered, so a byte arriving the cycle after DATA_LO is accepted normally and is never lost.
- CHECK accept: the checksum including this byte is evaluated.
  - 0: DONE = 1 for one cycle.
  - Otherwise: ERROR = 1 for one cycle.
  - Either way, HOLD falls on the same edge and the state returns to IDLE.
- LOAD is otherwise 0. ADDRESS and DATA_IN hold their last values between writes.
- Timeout: the gap counter clears on every accepted byte and increments every cycle while the state is not IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no RX_VALID: ERROR pulses next edge, HOLD drops, and the state returns to IDLE.
  - If RX_VALID coincides with expiry, the byte wins and no timeout occurs.
- A SYNC_BYTE value received mid-frame is treated as ordinary data; there is no resynchronisation.
- Reset mid-frame: the state returns to IDLE and LOAD drops on the reset edge. Words already written remain in RAM.
- DONE and ERROR are never high together. Neither pulses without a preceding SYNC.

Test Plan:
- Basic load: bytes A5 01 00 00 02 12 34 AB CD 3F -> LOAD pulses twice: (16'h0100, 16'h1234), then (16'h0101, 16'hABCD). DONE pulses once on the 3F edge. HOLD is high from the A5 edge to the 3F edge.
- Bad checksum: same frame with last byte 40 -> both writes still occur; ERROR pulses and DONE stays 0. Then an immediate correct frame loads and pulses DONE.
- Zero count and garbage: 00 FF A5 00 10 00 00 F0 -> the leading 00 and FF are ignored; no LOAD; DONE pulses.
- Address wrap: A5 FF FF 00 02 11 11 22 22 9A -> writes (16'hFFFF, 16'h1111) then (16'h0000, 16'h2222); DONE.
- Timeout with TIMEOUT_CYCLES = 16: send A5 01, then silence -> ERROR pulses 16 cycles after the 01 accept, HOLD drops, and a fresh frame is then accepted. Repeat with a byte landing exactly on expiry -> no ERROR.
- Reset mid-frame: assert RESET after the first DATA_HI byte -> all outputs 0 next edge and no LOAD; the following complete frame succeeds.

Source files
------------

// File: rtl/ram_loader_if.sv
// Bus bundle between the UART byte source, the boot loader and the RAM write port.
// Also carries the loader's FSM state out for observation.
interface ram_loader_if;
  // RX_VALID is a one-cycle strobe with no ready/backpressure: whenever it is
  // high, RX_DATA is consumed on that rising edge. LOAD is a one-cycle write
  // strobe qualifying ADDRESS/DATA_IN; the RAM must take it unconditionally.
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        LOAD;
  logic [15:0] ADDRESS;
  logic [15:0] DATA_IN;
  logic        HOLD;
  logic        DONE;
  logic        ERROR;
  logic [2:0]  fsm_state;

  modport master (
    input  RX_DATA, RX_VALID,
    output LOAD, ADDRESS, DATA_IN, HOLD, DONE, ERROR, fsm_state
  );

  modport slave (
    output RX_DATA, RX_VALID,
    input  LOAD, ADDRESS, DATA_IN, HOLD, DONE, ERROR, fsm_state
  );
endinterface

// File: rtl/ram_loader.sv
// Serial boot loader: parses SYNC/ADDR/CNT/DATA.../CHK frames from a byte stream
// and issues RAM write strobes, stalling the CPU for the duration of a frame.
module ram_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic         CLK,
  input  logic         RESET,
  ram_loader_if.master bus
);

  localparam int GW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_CNT_HI  = 3'd3,
    S_CNT_LO  = 3'd4,
    S_DATA_HI = 3'd5,
    S_DATA_LO = 3'd6,
    S_CHECK   = 3'd7
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [15:0]     wr_ptr;
  logic [15:0]     count;
  logic [7:0]      data_hi;
  logic [7:0]      csum;
  logic [GW-1:0]   gap;

  logic            load_q;
  logic [15:0]     addr_q;
  logic [15:0]     data_q;
  logic            hold_q;
  logic            done_q;
  logic            error_q;

  logic            accept;
  logic            expired;
  logic [7:0]      csum_sum;
  logic            write_word;
  logic            frame_ok;
  logic            frame_bad;

  assign accept   = bus.RX_VALID;
  assign csum_sum = csum + bus.RX_DATA;
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign expired  = (state != S_IDLE) && !bus.RX_VALID && (gap == GAP_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    write_word = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    if (expired) begin
      state_next = S_IDLE;
      frame_bad  = 1'b1;
    end else if (accept) begin
      case (state)
        S_IDLE: begin
          if (bus.RX_DATA == SYNC_BYTE) state_next = S_ADDR_HI;
        end
        S_ADDR_HI: state_next = S_ADDR_LO;
        S_ADDR_LO: state_next = S_CNT_HI;
        S_CNT_HI:  state_next = S_CNT_LO;
        S_CNT_LO: begin
          if ({count[15:8], bus.RX_DATA} == 16'h0000) state_next = S_CHECK;
          else                                        state_next = S_DATA_HI;
        end
        S_DATA_HI: state_next = S_DATA_LO;
        S_DATA_LO: begin
          write_word = 1'b1;
          if (count == 16'd1) state_next = S_CHECK;
          else                state_next = S_DATA_HI;
        end
        S_CHECK: begin
          state_next = S_IDLE;
          if (csum_sum == 8'h00) frame_ok  = 1'b1;
          else                   frame_bad = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr  <= 16'h0000;
      count   <= 16'h0000;
      data_hi <= 8'h00;
      csum    <= 8'h00;
      gap     <= '0;
      load_q  <= 1'b0;
      addr_q  <= 16'h0000;
      data_q  <= 16'h0000;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      load_q  <= write_word;
      done_q  <= frame_ok;
      error_q <= frame_bad;
      hold_q  <= (state_next != S_IDLE);

      if (accept || state_next == S_IDLE) gap <= '0;
      else                                gap <= gap + GW'(1);

      if (accept) begin
        case (state)
          S_IDLE: begin
            if (bus.RX_DATA == SYNC_BYTE) csum <= 8'h00;
          end
          S_ADDR_HI: begin
            wr_ptr[15:8] <= bus.RX_DATA;
            csum         <= csum_sum;
          end
          S_ADDR_LO: begin
            wr_ptr[7:0] <= bus.RX_DATA;
            csum        <= csum_sum;
          end
          S_CNT_HI: begin
            count[15:8] <= bus.RX_DATA;
            csum        <= csum_sum;
          end
          S_CNT_LO: begin
            count[7:0] <= bus.RX_DATA;
            csum       <= csum_sum;
          end
          S_DATA_HI: begin
            data_hi <= bus.RX_DATA;
            csum    <= csum_sum;
          end
          S_DATA_LO: begin
            addr_q <= wr_ptr;
            data_q <= {data_hi, bus.RX_DATA};
            wr_ptr <= wr_ptr + 16'd1;
            count  <= count - 16'd1;
            csum   <= csum_sum;
          end
          S_CHECK: csum <= csum_sum;
          default: csum <= csum;
        endcase
      end
    end
  end

  assign bus.LOAD      = load_q;
  assign bus.ADDRESS   = addr_q;
  assign bus.DATA_IN   = data_q;
  assign bus.HOLD      = hold_q;
  assign bus.DONE      = done_q;
  assign bus.ERROR     = error_q;
  assign bus.fsm_state = state;

endmodule
